// File: rtl/reset_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding and
// the counter-width helper used to size the hold and watchdog counters.
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_SOFT = 2'd1,
        CAUSE_WDOG = 2'd2
    } cause_e;

    // A counter for n states needs $clog2(n) bits, but never less than one.
    function automatic int cnt_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert flop chain; the output goes high STAGES clock
// edges after rst_n releases and drops immediately when rst_n falls.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [STAGES-1:0] chain_r;

    // Shift ones in from the bottom once the board reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain_r[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: synchronised POR release with a minimum hold time,
// plus software-requested and watchdog resets with cause reporting.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int WDOG_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst_req,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    output logic       sys_rst_n,
    output logic       rst_done,
    output logic [1:0] rst_cause,
    output logic       busy
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int WDOG_W = cnt_width(WDOG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'sd1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 32'sd1);

    state_e            state_r;
    cause_e            rst_cause_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [WDOG_W-1:0] wdog_cnt_r;
    logic              sys_rst_n_r;
    logic              rst_done_r;
    logic              busy_r;
    logic              sync_rel_s;
    logic              wdog_expire_s;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rel_s)
    );

    // Watchdog expiry; a kick on the terminal cycle suppresses it.
    always_comb begin
        wdog_expire_s = 1'b0;
        if ((state_r == RUN) && wdog_en && !wdog_kick && (wdog_cnt_r == WDOG_LAST)) begin
            wdog_expire_s = 1'b1;
        end else begin
            wdog_expire_s = 1'b0;
        end
    end

    // Sequencer FSM with registered reset, done pulse, cause and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ASSERT;
            rst_cause_r <= CAUSE_POR;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            wdog_cnt_r  <= {WDOG_W{1'b0}};
            sys_rst_n_r <= 1'b0;
            rst_done_r  <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            rst_done_r <= 1'b0;
            case (state_r)
                ASSERT: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    wdog_cnt_r <= {WDOG_W{1'b0}};
                    if (sync_rel_s) begin
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    wdog_cnt_r <= {WDOG_W{1'b0}};
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r     <= RUN;
                        sys_rst_n_r <= 1'b1;
                        rst_done_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // Soft request has priority over a simultaneous expiry.
                    if (soft_rst_req) begin
                        state_r     <= HOLD;
                        rst_cause_r <= CAUSE_SOFT;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        wdog_cnt_r  <= {WDOG_W{1'b0}};
                        sys_rst_n_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else if (wdog_expire_s) begin
                        state_r     <= HOLD;
                        rst_cause_r <= CAUSE_WDOG;
                        hold_cnt_r  <= {HOLD_W{1'b0}};
                        wdog_cnt_r  <= {WDOG_W{1'b0}};
                        sys_rst_n_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else if (!wdog_en || wdog_kick) begin
                        wdog_cnt_r <= {WDOG_W{1'b0}};
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
                    end
                end
                default: begin
                    state_r     <= ASSERT;
                    hold_cnt_r  <= {HOLD_W{1'b0}};
                    wdog_cnt_r  <= {WDOG_W{1'b0}};
                    sys_rst_n_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign sys_rst_n = sys_rst_n_r;
    assign rst_done  = rst_done_r;
    assign rst_cause = rst_cause_r;
    assign busy      = busy_r;

endmodule
